// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host/transmitter-side bundle of the UART TX feeder (optional UART_TX_FEEDER_OVF_EN)
interface uart_tx_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_din;
  logic              tx_done_tick;
`ifdef UART_TX_FEEDER_OVF_EN
  logic              ovf;
  logic              ovf_clr;

  modport master (
    output wr_en, wr_data, tx_done_tick, ovf_clr,
    input  full, empty, count, busy, tx_start, tx_din, ovf
  );
  modport slave (
    input  wr_en, wr_data, tx_done_tick, ovf_clr,
    output full, empty, count, busy, tx_start, tx_din, ovf
  );
`else
  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, busy, tx_start, tx_din
  );
  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, busy, tx_start, tx_din
  );
`endif
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte launcher for a UART transmitter (optional UART_TX_FEEDER_OVF_EN)
module uart_tx_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_feeder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  state_t            state_q;
  logic              tx_start_q, busy_q;
  logic [DATA_W-1:0] tx_din_q;
  logic              wr_acc, pop;

  // A write is judged against the registered full flag, so a same-cycle pop never makes room.
  assign wr_acc = bus.wr_en && !full_q;
  assign pop    = (state_q == S_IDLE) && !empty_q;

  // Occupancy next-state: a simultaneous accepted write and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (wr_acc && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_acc && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage, pointers and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem_q[wr_ptr_q] <= bus.wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Launch FSM: pop head into tx_din with a one-cycle start pulse, then wait for the stop bit to end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_start_q <= 1'b0;
          if (pop) begin
            tx_din_q   <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_done_tick) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_q;

  // Sticky overflow flag; a write-while-full in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full_q) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_din   = tx_din_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder (optional UART_TX_FEEDER_OVF_EN)
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  uart_tx_feeder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_tx_feeder #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbq [$];
  int   start_log [$];
  int   n_checks = 0;
  int   n_err = 0;
  int   nstarts = 0;
  logic prev_start = 1'b0;
  logic done_r = 1'b0;
  logic auto_en = 1'b0;
  int   auto_dly = 3;
  int   auto_cnt = 0;
  int   done_cyc = 0;
  logic gap_pend = 1'b0;

  assign bus.tx_done_tick = done_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then model the transmitter just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (!reset) begin
      if (bus.tx_start) begin
        chk("start_width", {31'b0, prev_start}, 0);
        if (sbq.size() == 0) chk("spurious_start", {31'b0, bus.tx_start}, 0);
        else chk("tx_din", {24'b0, bus.tx_din}, {24'b0, sbq.pop_front()});
        if (gap_pend) begin
          chk("done_to_start", cyc - done_cyc, 2);
          gap_pend = 1'b0;
        end
        start_log.push_back(cyc);
        nstarts++;
        if (auto_en) auto_cnt = auto_dly;
      end
      if (bus.count > 5'd16) chk("count_range", {27'b0, bus.count}, 16);
    end
    prev_start = reset ? 1'b0 : bus.tx_start;
    @(posedge clk);
    #1;
    done_r = 1'b0;
    if (auto_cnt > 0) begin
      auto_cnt--;
      if (auto_cnt == 0) begin
        done_r   = 1'b1;
        done_cyc = cyc;
        gap_pend = (sbq.size() > 0);
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input bit accepted);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accepted) sbq.push_back(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int g;
    g = 0;
    while (nstarts < n && g < budget) begin
      step();
      g++;
    end
    chk(tag, nstarts, n);
  endtask

  initial begin
    int w, base;
    logic [7:0] d;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
`ifdef UART_TX_FEEDER_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    idle(3);
    reset = 1'b0;
    chk("rst_empty", {31'b0, bus.empty}, 1);
    chk("rst_full", {31'b0, bus.full}, 0);
    chk("rst_count", {27'b0, bus.count}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_tx_start", {31'b0, bus.tx_start}, 0);
    chk("rst_tx_din", {24'b0, bus.tx_din}, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("rst_ovf", {31'b0, bus.ovf}, 0);
`endif
    idle(2);

    // single byte, manual done
    w = cyc;
    push(8'hA5, 1);
    wait_starts("t1_start", 1, 10);
    chk("t1_latency", start_log[0] - w, 2);
    idle(8);
    chk("t1_busy_hold", {31'b0, bus.busy}, 1);
    chk("t1_din_hold", {24'b0, bus.tx_din}, 8'hA5);
    chk("t1_start_low", {31'b0, bus.tx_start}, 0);
    done_r = 1'b1;
    step();
    step();
    chk("t1_busy_end", {31'b0, bus.busy}, 0);
    chk("t1_empty_end", {31'b0, bus.empty}, 1);
    idle(3);
    chk("t1_no_restart", nstarts, 1);

    // burst with autonomous transmitter
    auto_en = 1'b1;
    auto_dly = 3;
    base = nstarts;
    w = cyc;
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h03, 1);
    wait_starts("t2_starts", base + 3, 60);
    chk("t2_latency", start_log[base] - w, 2);
    idle(8);
    chk("t2_empty", {31'b0, bus.empty}, 1);
    chk("t2_busy", {31'b0, bus.busy}, 0);

    // fill to full with done held low
    auto_en = 1'b0;
    base = nstarts;
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i), 1);
    chk("t3_count16", {27'b0, bus.count}, 16);
    chk("t3_full", {31'b0, bus.full}, 1);
    push(8'hEE, 0);
    chk("t3_drop_count", {27'b0, bus.count}, 16);
    chk("t3_drop_full", {31'b0, bus.full}, 1);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("t3_ovf_set", {31'b0, bus.ovf}, 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", {31'b0, bus.ovf}, 0);
    bus.ovf_clr = 1'b1;
    push(8'hEF, 0);
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_set_wins", {31'b0, bus.ovf}, 1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
`endif
    auto_en = 1'b1;
    done_r = 1'b1;
    step();
    wait_starts("t3_drain", base + 17, 400);
    idle(8);
    chk("t3_empty", {31'b0, bus.empty}, 1);

    // wrap: interleaved pushes and pops, random data
    base = nstarts;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      push(d, 1);
      if (i % 4 != 0) idle(5);
    end
    wait_starts("t4_drain", base + 40, 600);
    idle(8);
    chk("t4_empty", {31'b0, bus.empty}, 1);
    chk("t4_count", {27'b0, bus.count}, 0);

    // simultaneous push and pop at count 1
    auto_en = 1'b0;
    base = nstarts;
    push(8'h11, 1);
    push(8'h22, 1);
    chk("t5_count_sim", {27'b0, bus.count}, 1);
    chk("t5_start", {31'b0, bus.tx_start}, 1);
    chk("t5_din", {24'b0, bus.tx_din}, 8'h11);
    step();
    chk("t5_count_hold", {27'b0, bus.count}, 1);
    idle(2);
    done_r = 1'b1;
    step();
    wait_starts("t5_next", base + 2, 10);
    idle(3);
    done_r = 1'b1;
    step();
    idle(3);
    chk("t5_empty", {31'b0, bus.empty}, 1);

    // reset mid-WAIT with five bytes queued
    base = nstarts;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1);
    idle(3);
    chk("t6_count5", {27'b0, bus.count}, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sbq.delete();
    gap_pend = 1'b0;
    auto_cnt = 0;
    chk("t6_count", {27'b0, bus.count}, 0);
    chk("t6_empty", {31'b0, bus.empty}, 1);
    chk("t6_tx_start", {31'b0, bus.tx_start}, 0);
    chk("t6_busy", {31'b0, bus.busy}, 0);
    chk("t6_tx_din", {24'b0, bus.tx_din}, 0);
    step();
    chk("t6_tx_start_next", {31'b0, bus.tx_start}, 0);
    done_r = 1'b1;
    step();
    idle(5);
    chk("t6_no_pop", nstarts, base + 1);
    chk("t6_count_after", {27'b0, bus.count}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
